riscv_fetch_aligner: RTL

- Instruction realigner between the fetch buffer and the compressed decoder in stage01_fetch.
- Takes word-aligned 32-bit fetch words and emits one instruction per handshake: either a raw 16-bit compressed instruction (zero-extended) or a full 32-bit instruction, with its exact PC.
- Handles 32-bit instructions that straddle two fetch words, two compressed instructions packed in one word, and redirects to halfword-aligned targets.

---
 rtl/riscv_fetch_aligner_if.sv | 27 ++
 rtl/riscv_fetch_aligner.sv | 123 ++++++++++++
 2 files changed

// File: rtl/riscv_fetch_aligner_if.sv
// Fetch-side and decode-side handshake bundle for the RVC fetch aligner.
// The slave modport is the aligner's view; the master modport is its environment.
interface riscv_fetch_aligner_if #(
   parameter int unsigned XLEN = 32
);
   logic            flush_i;
   logic [XLEN-1:0] flush_pc_i;
   logic            fetch_valid_i;
   logic            fetch_ready_o;
   logic [31:0]     fetch_data_i;
   logic [XLEN-1:0] fetch_pc_i;
   logic            inst_valid_o;
   logic            inst_ready_i;
   logic [31:0]     inst_o;
   logic [XLEN-1:0] inst_pc_o;
   logic            inst_compressed_o;

   modport slave (
      input  flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, fetch_pc_i, inst_ready_i,
      output fetch_ready_o, inst_valid_o, inst_o, inst_pc_o, inst_compressed_o
   );

   modport master (
      output flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, fetch_pc_i, inst_ready_i,
      input  fetch_ready_o, inst_valid_o, inst_o, inst_pc_o, inst_compressed_o
   );
endinterface

// File: rtl/riscv_fetch_aligner.sv
// Realigns word-aligned fetch words into single 16/32-bit instructions with exact PCs,
// handling packed compressed pairs, word-straddling 32-bit instructions and odd redirects.
module riscv_fetch_aligner #(
   parameter int unsigned XLEN     = 32,
   parameter bit          ENABLE_C = 1'b1
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   riscv_fetch_aligner_if.slave bus
);
   typedef enum logic [1:0] {S_EMPTY, S_C16, S_HI32, S_SKIP} state_t;

   state_t          state;
   logic [15:0]     r_half;
   logic [XLEN-1:0] r_pc;

   logic [31:0]     d;
   logic [XLEN-1:0] pc_plus2;
   logic            lo_c;
   logic            hi_c;
   logic            inst_valid;
   logic            fetch_ready;
   logic [31:0]     inst;
   logic [XLEN-1:0] inst_pc;
   logic            inst_fire;
   logic            word_fire;
   logic            unused_flush_bits;

   assign d                 = bus.fetch_data_i;
   assign pc_plus2          = bus.fetch_pc_i + XLEN'(2);
   assign lo_c              = d[1:0] != 2'b11;
   assign hi_c              = d[17:16] != 2'b11;
   assign unused_flush_bits = ^{bus.flush_pc_i[XLEN-1:2], bus.flush_pc_i[0]};

   // Outputs are forced to zero both in reset and in the flush cycle so nothing transfers.
   always_comb begin
      inst_valid  = 1'b0;
      fetch_ready = 1'b0;
      inst        = '0;
      inst_pc     = '0;
      if (rst_ni && !bus.flush_i) begin
         if (!ENABLE_C) begin
            inst_valid  = bus.fetch_valid_i;
            fetch_ready = bus.inst_ready_i;
            inst        = d;
            inst_pc     = bus.fetch_pc_i;
         end else begin
            unique case (state)
               S_EMPTY: begin
                  inst_valid  = bus.fetch_valid_i;
                  fetch_ready = bus.inst_ready_i;
                  inst        = lo_c ? {16'h0000, d[15:0]} : d;
                  inst_pc     = bus.fetch_pc_i;
               end
               S_C16: begin
                  inst_valid  = 1'b1;
                  inst        = {16'h0000, r_half};
                  inst_pc     = r_pc;
               end
               S_HI32: begin
                  inst_valid  = bus.fetch_valid_i;
                  fetch_ready = bus.inst_ready_i;
                  inst        = {d[15:0], r_half};
                  inst_pc     = r_pc;
               end
               S_SKIP: begin
                  fetch_ready = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign inst_fire = inst_valid & bus.inst_ready_i;
   assign word_fire = bus.fetch_valid_i & fetch_ready;

   assign bus.inst_valid_o      = inst_valid;
   assign bus.fetch_ready_o     = fetch_ready;
   assign bus.inst_o            = inst;
   assign bus.inst_pc_o         = inst_pc;
   assign bus.inst_compressed_o = ENABLE_C && inst_valid && (inst[1:0] != 2'b11);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= S_EMPTY;
         r_half <= '0;
         r_pc   <= '0;
      end else if (bus.flush_i) begin
         state  <= (ENABLE_C && bus.flush_pc_i[1]) ? S_SKIP : S_EMPTY;
         r_half <= '0;
      end else if (ENABLE_C) begin
         unique case (state)
            S_EMPTY: begin
               if (inst_fire && lo_c) begin
                  r_half <= d[31:16];
                  r_pc   <= pc_plus2;
                  state  <= hi_c ? S_C16 : S_HI32;
               end
            end
            S_C16: begin
               if (inst_fire) state <= S_EMPTY;
            end
            S_HI32: begin
               if (inst_fire) begin
                  r_half <= d[31:16];
                  r_pc   <= pc_plus2;
                  state  <= hi_c ? S_C16 : S_HI32;
               end
            end
            S_SKIP: begin
               // Low halfword lies before the redirect target and is dropped.
               if (word_fire) begin
                  r_half <= d[31:16];
                  r_pc   <= pc_plus2;
                  state  <= hi_c ? S_C16 : S_HI32;
               end
            end
            default: state <= S_EMPTY;
         endcase
      end
   end
endmodule
